updn_counter: RTL and testbench

UPDN_COUNTER -- requirements
Module: updn_counter

---
 rtl/updn_counter.sv | 128 ++++++++++++
 tb/tb_updn_counter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/updn_counter.sv
// Up/down counter with programmable terminal count, variable step size and a
// choice of modulo-wrap or clamp behaviour at the range boundaries.
// Flags: tc (combinational terminal count), wrap (one-cycle boundary pulse),
// ovf (sticky boundary flag, cleared only by reset/clear).
module updn_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             count_en,
  input  logic             down,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Terminal count at native width and at the widened arithmetic width.
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   ONE_E = (WIDTH+1)'(1);
  // Modulus of the count range; MAX <= 2**WIDTH-1 so this always fits.
  localparam logic [WIDTH:0]   MOD_E = MAX_E + ONE_E;

  // State
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  // Next-state
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_ovf_nxt;

  // Step datapath, one bit wider than the count so sums never truncate
  logic [WIDTH:0]   w_cnt_e;
  logic [WIDTH:0]   w_step_e;
  logic [WIDTH:0]   w_s;
  logic [WIDTH:0]   w_up_sum;
  logic             w_up_cross;
  logic             w_dn_cross;
  logic [WIDTH-1:0] w_up_next;
  logic [WIDTH-1:0] w_dn_next;
  logic             w_up_flag;
  logic             w_dn_flag;
  logic [WIDTH-1:0] w_load_val;

  // Step arithmetic: effective step, candidate next counts and crossing detection
  always_comb begin
    w_cnt_e    = {1'b0, r_count};
    w_step_e   = {1'b0, step};
    // Steps larger than the range behave as a full-range step.
    w_s        = (w_step_e > MAX_E) ? MAX_E : w_step_e;

    w_up_sum   = w_cnt_e + w_s;
    w_up_cross = (w_up_sum > MAX_E);
    w_dn_cross = (w_s > w_cnt_e);

    if (!w_up_cross) begin
      w_up_next = WIDTH'(w_up_sum);
    end else if (SATURATE) begin
      w_up_next = MAX_W;
    end else begin
      w_up_next = WIDTH'(w_up_sum - MOD_E);
    end

    if (!w_dn_cross) begin
      w_dn_next = WIDTH'(w_cnt_e - w_s);
    end else if (SATURATE) begin
      w_dn_next = '0;
    end else begin
      w_dn_next = WIDTH'(w_cnt_e + MOD_E - w_s);
    end

    // A clamped counter already sitting at MAX does not flag again when pushed up.
    w_up_flag  = w_up_cross && (!SATURATE || (r_count != MAX_W));
    w_dn_flag  = w_dn_cross;

    // Out-of-range load values are clamped so the count never exceeds MAX.
    w_load_val = (data_in > MAX_W) ? MAX_W : data_in;
  end

  // Next-state selection in priority order: reset, clear, load, count
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_ovf_nxt   = r_ovf;

    if (reset || clear) begin
      w_count_nxt = '0;
      w_wrap_nxt  = 1'b0;
      w_ovf_nxt   = 1'b0;
    end else if (load) begin
      w_count_nxt = w_load_val;
    end else if (count_en) begin
      if (down) begin
        w_count_nxt = w_dn_next;
        w_wrap_nxt  = w_dn_flag;
      end else begin
        w_count_nxt = w_up_next;
        w_wrap_nxt  = w_up_flag;
      end
      w_ovf_nxt = r_ovf | w_wrap_nxt;
    end
  end

  // State registers; reset is folded into the next-state logic (synchronous)
  always_ff @(posedge clock) begin
    r_count <= w_count_nxt;
    r_wrap  <= w_wrap_nxt;
    r_ovf   <= w_ovf_nxt;
  end

  // Outputs: count and flags straight from registers, tc follows current direction
  always_comb begin
    data_out = r_count;
    wrap     = r_wrap;
    ovf      = r_ovf;
    tc       = down ? (r_count == '0) : (r_count == MAX_W);
  end

endmodule

// File: tb/tb_updn_counter.sv
// Directed self-checking bench for updn_counter: a WIDTH=4/MAX=9 wrap-mode
// instance, a WIDTH=4/MAX=9 clamp-mode instance and a default WIDTH=8 instance.
module tb_updn_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: WIDTH=4, MAX=9, wrap mode
  logic       a_reset, a_clear, a_load, a_en, a_down;
  logic [3:0] a_data, a_step, a_out;
  logic       a_tc, a_wrap, a_ovf;
  // Instance B: WIDTH=4, MAX=9, clamp mode
  logic       b_reset, b_clear, b_load, b_en, b_down;
  logic [3:0] b_data, b_step, b_out;
  logic       b_tc, b_wrap, b_ovf;
  // Instance C: WIDTH=8, default MAX=255, wrap mode
  logic       c_reset, c_clear, c_load, c_en, c_down;
  logic [7:0] c_data, c_step, c_out;
  logic       c_tc, c_wrap, c_ovf;

  updn_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_a (
    .clock(clock), .reset(a_reset), .clear(a_clear), .load(a_load), .data_in(a_data),
    .count_en(a_en), .down(a_down), .step(a_step), .data_out(a_out), .tc(a_tc),
    .wrap(a_wrap), .ovf(a_ovf)
  );

  updn_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_b (
    .clock(clock), .reset(b_reset), .clear(b_clear), .load(b_load), .data_in(b_data),
    .count_en(b_en), .down(b_down), .step(b_step), .data_out(b_out), .tc(b_tc),
    .wrap(b_wrap), .ovf(b_ovf)
  );

  updn_counter #(.WIDTH(8)) u_c (
    .clock(clock), .reset(c_reset), .clear(c_clear), .load(c_load), .data_in(c_data),
    .count_en(c_en), .down(c_down), .step(c_step), .data_out(c_out), .tc(c_tc),
    .wrap(c_wrap), .ovf(c_ovf)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_clear = 1'b0; a_load = 1'b0; a_en = 1'b0; a_down = 1'b0;
    a_data  = 4'd0; a_step  = 4'd0;
    b_reset = 1'b1; b_clear = 1'b0; b_load = 1'b0; b_en = 1'b0; b_down = 1'b0;
    b_data  = 4'd0; b_step  = 4'd0;
    c_reset = 1'b1; c_clear = 1'b0; c_load = 1'b0; c_en = 1'b0; c_down = 1'b0;
    c_data  = 8'd0; c_step  = 8'd0;

    // ---------------- Instance A: wrap mode ----------------
    tick;
    chk("a_rst_cnt", a_out, 0);
    chk("a_rst_wrap", a_wrap, 0);
    chk("a_rst_ovf", a_ovf, 0);

    // Count 1..9,0,1,2 with step 1
    a_reset = 1'b0; a_en = 1'b1; a_step = 4'd1;
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("a_run_cnt", a_out, (i + 1) % 10);
      chk("a_run_tc", a_tc, ((i + 1) % 10) == 9);
      chk("a_run_wrap", a_wrap, i == 9);
      chk("a_run_ovf", a_ovf, i >= 9);
    end

    // Load 7 beats count_en; wrap cleared, ovf kept
    a_load = 1'b1; a_data = 4'd7;
    tick;
    chk("a_ld7_cnt", a_out, 7);
    chk("a_ld7_wrap", a_wrap, 0);
    chk("a_ld7_ovf", a_ovf, 1);

    // 7 + 4 wraps to 1
    a_load = 1'b0; a_step = 4'd4;
    tick;
    chk("a_up4_cnt", a_out, 1);
    chk("a_up4_wrap", a_wrap, 1);

    // 1 - 3 wraps to 8
    a_step = 4'd3; a_down = 1'b1;
    tick;
    chk("a_dn3_cnt", a_out, 8);
    chk("a_dn3_wrap", a_wrap, 1);
    chk("a_dn3_tc", a_tc, 0);

    // Idle: count held, wrap drops, ovf sticks
    a_en = 1'b0;
    tick;
    chk("a_idle_cnt", a_out, 8);
    chk("a_idle_wrap", a_wrap, 0);
    chk("a_idle_ovf", a_ovf, 1);

    // Load above MAX clamps
    a_load = 1'b1; a_data = 4'd15;
    tick;
    chk("a_ld15_cnt", a_out, 9);
    chk("a_ld15_tcdn", a_tc, 0);
    a_down = 1'b0;
    #1;
    chk("a_ld15_tcup", a_tc, 1);

    // 9 + 1 wraps to 0
    a_load = 1'b0; a_en = 1'b1; a_step = 4'd1;
    tick;
    chk("a_9to0_cnt", a_out, 0);
    chk("a_9to0_wrap", a_wrap, 1);

    // tc follows direction combinationally
    a_en = 1'b0; a_down = 1'b1;
    #1;
    chk("a_tc_dn0", a_tc, 1);
    a_down = 1'b0;
    #1;
    chk("a_tc_up0", a_tc, 0);

    // Simultaneous load and count_en: load wins, no wrap
    a_load = 1'b1; a_data = 4'd3; a_en = 1'b1;
    tick;
    chk("a_ldcnt_cnt", a_out, 3);
    chk("a_ldcnt_wrap", a_wrap, 0);

    // Step above MAX treated as 9: 3 + 9 -> 2
    a_load = 1'b0; a_step = 4'd15;
    tick;
    chk("a_big_up_cnt", a_out, 2);
    chk("a_big_up_wrap", a_wrap, 1);

    // 2 - 9 -> 3
    a_down = 1'b1;
    tick;
    chk("a_big_dn_cnt", a_out, 3);
    chk("a_big_dn_wrap", a_wrap, 1);

    // Clear beats load and count_en
    a_en = 1'b0; a_load = 1'b1; a_data = 4'd5;
    tick;
    chk("a_ld5_cnt", a_out, 5);
    a_clear = 1'b1; a_data = 4'd7; a_en = 1'b1; a_step = 4'd1; a_down = 1'b0;
    tick;
    chk("a_clr_cnt", a_out, 0);
    chk("a_clr_wrap", a_wrap, 0);
    chk("a_clr_ovf", a_ovf, 0);

    // Rebuild ovf, then reset beats load and count_en
    a_clear = 1'b0; a_en = 1'b0; a_data = 4'd9;
    tick;
    a_load = 1'b0; a_en = 1'b1;
    tick;
    chk("a_reovf_cnt", a_out, 0);
    chk("a_reovf_ovf", a_ovf, 1);
    a_load = 1'b1; a_data = 4'd5;
    tick;
    chk("a_ld5b_cnt", a_out, 5);
    a_reset = 1'b1;
    tick;
    chk("a_rst2_cnt", a_out, 0);
    chk("a_rst2_wrap", a_wrap, 0);
    chk("a_rst2_ovf", a_ovf, 0);
    // Reset held while count_en high, then counting resumes
    a_load = 1'b0;
    tick;
    chk("a_rsthold_cnt", a_out, 0);
    a_reset = 1'b0;
    tick;
    chk("a_resume_cnt", a_out, 1);

    // ---------------- Instance B: clamp mode ----------------
    tick;
    chk("b_rst_cnt", b_out, 0);
    chk("b_rst_ovf", b_ovf, 0);
    b_reset = 1'b0; b_load = 1'b1; b_data = 4'd8;
    tick;
    chk("b_ld8_cnt", b_out, 8);
    b_load = 1'b0; b_en = 1'b1; b_step = 4'd5;
    tick;
    chk("b_up1_cnt", b_out, 9);
    chk("b_up1_wrap", b_wrap, 1);
    chk("b_up1_ovf", b_ovf, 1);
    chk("b_up1_tc", b_tc, 1);
    tick;
    chk("b_up2_cnt", b_out, 9);
    chk("b_up2_wrap", b_wrap, 0);
    b_down = 1'b1; b_step = 4'd12;
    tick;
    chk("b_dn9_cnt", b_out, 0);
    chk("b_dn9_wrap", b_wrap, 0);
    b_step = 4'd1;
    tick;
    chk("b_dnclamp_cnt", b_out, 0);
    chk("b_dnclamp_wrap", b_wrap, 1);
    b_step = 4'd0;
    tick;
    chk("b_hold_cnt", b_out, 0);
    chk("b_hold_wrap", b_wrap, 0);
    chk("b_hold_ovf", b_ovf, 1);

    // ---------------- Instance C: WIDTH=8 ----------------
    c_load = 1'b1; c_data = 8'd255;
    c_reset = 1'b0;
    tick;
    chk("c_ld255_cnt", c_out, 255);
    chk("c_ld255_tc", c_tc, 1);
    chk("c_ld255_ovf", c_ovf, 0);
    c_load = 1'b0; c_en = 1'b1; c_step = 8'd1;
    tick;
    chk("c_wrap_cnt", c_out, 0);
    chk("c_wrap_wrap", c_wrap, 1);
    chk("c_wrap_ovf", c_ovf, 1);
    c_step = 8'd0;
    tick;
    chk("c_hold0_cnt", c_out, 0);
    chk("c_hold0_wrap", c_wrap, 0);
    c_load = 1'b1; c_data = 8'd100;
    tick;
    c_load = 1'b0;
    tick;
    chk("c_hold100_cnt", c_out, 100);
    c_step = 8'd200;
    tick;
    chk("c_up200_cnt", c_out, 44);
    chk("c_up200_wrap", c_wrap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
